// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the execute stage.
// One shift-add (MUL) or restoring shift-subtract (DIV) step per cycle, WIDTH steps per op.
module ex_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rd_val,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;      // MUL: running high half; DIV: partial remainder
    logic [WIDTH-1:0] quo;      // MUL: multiplier shifting out; DIV: dividend out / quotient in
    logic [WIDTH-1:0] opb;      // MUL: multiplicand magnitude; DIV: divisor magnitude
    logic             is_div;
    logic             neg_lo;
    logic             neg_hi;

    // operand decode at accept
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             accept, start_dbz, last;

    // datapath step
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh, div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] step_acc, step_quo;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] fix_lo, fix_hi;

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        a_neg     = op[0] & rs_val[WIDTH-1];
        b_neg     = op[0] & rd_val[WIDTH-1];
        a_mag     = a_neg ? (~rs_val + 1'b1) : rs_val;
        b_mag     = b_neg ? (~rd_val + 1'b1) : rd_val;
        accept    = start & ~flush & (state != RUN);
        start_dbz = op[1] & (rd_val == '0);
        last      = (state == RUN) && (cnt == CW'(WIDTH - 1));
    end

    always_comb begin
        mul_sum  = {1'b0, acc} + (quo[0] ? {1'b0, opb} : {(WIDTH + 1){1'b0}});
        // Remainder stays below the divisor, so bit WIDTH of the difference is a clean borrow flag.
        div_sh   = {acc, quo[WIDTH-1]};
        div_diff = div_sh - {1'b0, opb};
        div_ok   = ~div_diff[WIDTH];
        if (is_div) begin
            step_acc = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            step_quo = {quo[WIDTH-2:0], div_ok};
        end else begin
            step_acc = mul_sum[WIDTH:1];
            step_quo = {mul_sum[0], quo[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod     = {step_acc, step_quo};
        prod_fix = neg_lo ? (~prod + 1'b1) : prod;
        if (is_div) begin
            fix_lo = neg_lo ? (~step_quo + 1'b1) : step_quo;
            fix_hi = neg_hi ? (~step_acc + 1'b1) : step_acc;
        end else begin
            fix_lo = prod_fix[WIDTH-1:0];
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start)
                        state_nxt = start_dbz ? DONE : RUN;
                    else
                        state_nxt = IDLE;
                end
                RUN: begin
                    if (last)
                        state_nxt = DONE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            quo         <= '0;
            opb         <= '0;
            is_div      <= 1'b0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            result_lo   <= '0;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt    <= '0;
                acc    <= '0;
                quo    <= a_mag;
                opb    <= op[1] ? b_mag : a_mag;
                is_div <= op[1];
                neg_lo <= a_neg ^ b_neg;
                neg_hi <= a_neg;
                if (op[1] == 1'b0)
                    quo <= b_mag;
                if (start_dbz) begin
                    result_lo   <= '1;
                    result_hi   <= rs_val;
                    div_by_zero <= 1'b1;
                end else begin
                    div_by_zero <= 1'b0;
                end
            end else if (state == RUN && !flush) begin
                acc <= step_acc;
                quo <= step_quo;
                cnt <= cnt + 1'b1;
                if (last) begin
                    result_lo <= fix_lo;
                    result_hi <= fix_hi;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit with hand-computed expected results.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [1:0]  op;
    logic [31:0] rs_val, rd_val;
    logic        busy, done, div_by_zero;
    logic [31:0] result_lo, result_hi;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rd_val(rd_val), .flush(flush),
        .busy(busy), .done(done), .result_lo(result_lo),
        .result_hi(result_hi), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, count busy cycles (bounded), then check the done cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi, input logic exp_dbz,
                          input int unsigned exp_busy);
        int unsigned nb;
        int unsigned excl_bad;
        op = o; rs_val = a; rd_val = b; start = 1'b1;
        tick();
        start = 1'b0;
        nb = 0;
        excl_bad = 0;
        while (busy && nb < 100) begin
            if (done) excl_bad++;
            nb++;
            tick();
        end
        check({tag, " busy_cycles"}, 64'(nb), 64'(exp_busy));
        check({tag, " busy_done_excl"}, 64'(excl_bad), 64'd0);
        check({tag, " done"}, {63'd0, done}, 64'd1);
        check({tag, " lo"}, {32'd0, result_lo}, {32'd0, exp_lo});
        check({tag, " hi"}, {32'd0, result_hi}, {32'd0, exp_hi});
        check({tag, " dbz"}, {63'd0, div_by_zero}, {63'd0, exp_dbz});
    endtask

    initial begin
        int unsigned nd;
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00;
        rs_val = '0; rd_val = '0;
        tick(); tick();
        reset = 1'b0;
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset lo", {32'd0, result_lo}, 64'd0);
        check("reset hi", {32'd0, result_hi}, 64'd0);
        check("reset dbz", {63'd0, div_by_zero}, 64'd0);

        run_op("mulu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 32);
        tick();
        check("mulu_max done_pulse", {63'd0, done}, 64'd0);

        run_op("muls_neg", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0, 32);
        tick();
        run_op("divs_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 32);
        tick();
        run_op("divu_zero", 2'b10, 32'd10, 32'd0, 32'hFFFF_FFFF, 32'h0000_000A, 1'b1, 0);
        tick();
        check("divu_zero done_pulse", {63'd0, done}, 64'd0);

        // Overflow case, then a back-to-back start issued in the done cycle.
        run_op("divs_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 32);
        run_op("mulu_b2b", 2'b00, 32'd6, 32'd7, 32'd42, 32'd0, 1'b0, 32);
        tick();

        // Flush with simultaneous start at RUN iteration 10.
        op = 2'b00; rs_val = 32'hFFFF_FFFF; rd_val = 32'hFFFF_FFFF; start = 1'b1;
        tick();
        start = 1'b0;
        check("flush pre busy", {63'd0, busy}, 64'd1);
        repeat (10) tick();
        flush = 1'b1; start = 1'b1;
        tick();
        flush = 1'b0; start = 1'b0;
        check("flush busy", {63'd0, busy}, 64'd0);
        check("flush done", {63'd0, done}, 64'd0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) nd++;
            tick();
        end
        check("flush no_activity", 64'(nd), 64'd0);
        check("flush lo held", {32'd0, result_lo}, 64'd42);
        check("flush hi held", {32'd0, result_hi}, 64'd0);

        // Reset at RUN iteration 20.
        op = 2'b10; rs_val = 32'd1000; rd_val = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid busy", {63'd0, busy}, 64'd0);
        check("rst_mid done", {63'd0, done}, 64'd0);
        check("rst_mid lo", {32'd0, result_lo}, 64'd0);
        check("rst_mid hi", {32'd0, result_hi}, 64'd0);
        check("rst_mid dbz", {63'd0, div_by_zero}, 64'd0);
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
